pc_gen_param: RTL

Parametrised program-counter generator for the RV32I fetch stage, and the successor to the single-width PC register. It selects the next fetch address from trap, redirect, stall, fused-pair skip and sequential sources. It keeps a configurable-depth history of issued PCs for downstream pipeline stages and reports flush and stall-timeout status. It sits between the branch/jump resolution logic and the instruction memory address port.

---
 rtl/pc_gen_param.sv | 116 +++++++++++
 1 files changed

// File: rtl/pc_gen_param.sv
// Fetch-stage next-PC generator: trap / redirect / stall / fused-skip /
// sequential selection, issued-PC history, flush, misalign and stall-timeout.
module pc_gen_param #(
  parameter int unsigned              XLEN         = 32,
  parameter logic [XLEN-1:0]          RESET_VECTOR = '0,
  parameter int unsigned              HIST_DEPTH   = 2,
  parameter int unsigned              STALL_LIMIT  = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         trap_valid,
  input  logic [XLEN-1:0]              trap_vector,
  input  logic                         redirect_valid,
  input  logic                         jalr,
  input  logic [XLEN-1:0]              redirect_addr,
  input  logic                         load,
  input  logic                         dmem_valid,
  input  logic                         fuse_skip,
  output logic [XLEN-1:0]              pc_out,
  output logic [XLEN-1:0]              pre_pc,
  output logic [XLEN*HIST_DEPTH-1:0]   pc_hist,
  output logic                         flush,
  output logic                         misalign,
  output logic                         stall_timeout
);

  localparam int unsigned CW = $clog2(STALL_LIMIT + 1);

  logic [XLEN-1:0]                  r_pc;
  logic [HIST_DEPTH-1:0][XLEN-1:0]  r_hist;
  logic [CW-1:0]                    r_cnt;
  logic                             r_flush;
  logic                             r_mis;
  logic                             r_timeout;

  logic            w_redir;
  logic            w_stall;
  logic            w_take;
  logic            w_adv;
  logic            w_mis;
  logic [XLEN-1:0] w_raw;
  logic [XLEN-1:0] w_pc_nxt;
  logic [CW-1:0]   w_cnt_nxt;

  assign w_redir = redirect_valid | jalr;
  assign w_stall = load & ~dmem_valid;
  assign w_take  = trap_valid | w_redir;
  // A taken trap/redirect beats the stall, so history still advances then.
  assign w_adv   = w_take | ~w_stall;

  // Next-PC priority mux. Forcing bits[1:0] low also covers the jalr bit-0
  // clear; misalign reflects the target as presented, before any masking.
  always_comb begin
    w_raw    = '0;
    w_mis    = 1'b0;
    w_pc_nxt = r_pc + XLEN'(4);
    if (trap_valid) begin
      w_raw    = trap_vector;
      w_mis    = |trap_vector[1:0];
      w_pc_nxt = {w_raw[XLEN-1:2], 2'b00};
    end else if (w_redir) begin
      w_raw    = redirect_addr;
      w_mis    = |redirect_addr[1:0];
      w_pc_nxt = {w_raw[XLEN-1:2], 2'b00};
    end else if (w_stall) begin
      w_pc_nxt = r_pc;
    end else if (fuse_skip) begin
      w_pc_nxt = r_pc + XLEN'(8);
    end
  end

  // Stall counter: count stalled cycles, saturate at the limit, clear otherwise.
  always_comb begin
    w_cnt_nxt = '0;
    if (!w_adv) begin
      if (r_cnt == CW'(STALL_LIMIT)) w_cnt_nxt = r_cnt;
      else                           w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  // PC, status pulses and stall bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc      <= RESET_VECTOR;
      r_flush   <= 1'b0;
      r_mis     <= 1'b0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_flush   <= w_take;
      r_mis     <= w_mis;
      r_cnt     <= w_cnt_nxt;
      // Tracks the counter value being loaded so timeout equals (counter == limit).
      r_timeout <= (w_cnt_nxt == CW'(STALL_LIMIT));
    end
  end

  // Issued-PC history: shift on every advancing cycle, hold during a stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= RESET_VECTOR;
    end else if (w_adv) begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) r_hist[i] <= r_hist[i-1];
      r_hist[0] <= r_pc;
    end
  end

  assign pc_out        = r_pc;
  assign pre_pc        = r_hist[0];
  assign pc_hist       = r_hist;
  assign flush         = r_flush;
  assign misalign      = r_mis;
  assign stall_timeout = r_timeout;

endmodule
